// File: rtl/pin_lock_pkg.sv
// Shared types and helpers for the PIN lock controller.
// Provides the state/y_out encoding and the BCD validity check.
package pin_lock_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'b00,
        ST_UNLOCKED = 2'b01,
        ST_BLOCKED  = 2'b10,
        ST_PROGRAM  = 2'b11
    } state_t;

    localparam int unsigned MAX_DIGITS = 16;
    localparam int unsigned CODE_MAX_W = 4 * MAX_DIGITS;

    // Fixed-bound loop with a digit mask so the check unrolls for any DIGITS.
    function automatic logic is_bcd(input logic [CODE_MAX_W-1:0] code,
                                    input int unsigned digits);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits && code[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/pin_lock_ctrl_match.sv
// Combinational code classifier: BCD validity and comparison against
// the stored user PIN and the master code.
module bcd_code_match
    import pin_lock_pkg::*;
#(
    parameter int unsigned DIGITS = 2
) (
    input  logic [4*DIGITS-1:0] code,
    input  logic [4*DIGITS-1:0] pin,
    input  logic [4*DIGITS-1:0] master,
    output logic                bcd_ok,
    output logic                eq_pin,
    output logic                eq_master
);

    always_comb begin
        bcd_ok    = is_bcd(CODE_MAX_W'(code), DIGITS);
        eq_pin    = (code == pin);
        eq_master = (code == master);
    end

endmodule

// File: rtl/pin_lock_ctrl.sv
// N-digit PIN lock: try counter with lockout, master-code recovery,
// auto-relock timer and user PIN programming. All outputs registered.
module pin_lock_ctrl
    import pin_lock_pkg::*;
#(
    parameter int unsigned          DIGITS        = 2,
    parameter int unsigned          MAX_TRIES     = 3,
    parameter logic [4*DIGITS-1:0]  USER_PIN_INIT = 'h03,
    parameter logic [4*DIGITS-1:0]  MASTER_PIN    = 'h80,
    parameter int unsigned          UNLOCK_CYCLES = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [4*DIGITS-1:0]              x_in,
    input  logic                             x_valid,
    input  logic                             prog_en,
    output logic [1:0]                       y_out,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
    output logic                             alarm,
    output logic                             err
);

    localparam int unsigned W   = 4 * DIGITS;
    localparam int unsigned TW  = $clog2(MAX_TRIES + 1);
    localparam int unsigned TMW = $clog2(UNLOCK_CYCLES + 1);
    localparam logic [TW-1:0]  TRIES_MAX = TW'(MAX_TRIES);
    localparam logic [TMW-1:0] TIMER_MAX = TMW'(UNLOCK_CYCLES);

    state_t         state;
    logic [W-1:0]   pin;
    logic [TMW-1:0] timer;
    logic           bcd_ok;
    logic           eq_pin;
    logic           eq_master;
    logic           timer_last;

    bcd_code_match #(
        .DIGITS(DIGITS)
    ) u_match (
        .code      (x_in),
        .pin       (pin),
        .master    (MASTER_PIN),
        .bcd_ok    (bcd_ok),
        .eq_pin    (eq_pin),
        .eq_master (eq_master)
    );

    // Relock on the idle cycle that would take the timer to zero, so an idle
    // UNLOCKED/PROGRAM stretch lasts exactly UNLOCK_CYCLES cycles.
    assign timer_last = (timer <= TMW'(1));
    assign y_out      = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_LOCKED;
            tries_left <= TRIES_MAX;
            alarm      <= 1'b0;
            err        <= 1'b0;
            pin        <= USER_PIN_INIT;
            timer      <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_LOCKED: begin
                    if (x_valid) begin
                        if (!bcd_ok) begin
                            err <= 1'b1;
                        end else if (eq_pin || eq_master) begin
                            state      <= ST_UNLOCKED;
                            tries_left <= TRIES_MAX;
                            timer      <= TIMER_MAX;
                        end else if (tries_left <= TW'(1)) begin
                            tries_left <= '0;
                            state      <= ST_BLOCKED;
                            alarm      <= 1'b1;
                        end else begin
                            tries_left <= tries_left - TW'(1);
                        end
                    end
                end
                ST_BLOCKED: begin
                    if (x_valid) begin
                        if (!bcd_ok) begin
                            err <= 1'b1;
                        end else if (eq_master) begin
                            state      <= ST_LOCKED;
                            tries_left <= TRIES_MAX;
                            alarm      <= 1'b0;
                        end
                    end
                end
                ST_UNLOCKED: begin
                    if (prog_en) begin
                        state <= ST_PROGRAM;
                        timer <= TIMER_MAX;
                        if (x_valid && !bcd_ok) err <= 1'b1;
                    end else if (x_valid && bcd_ok) begin
                        state <= ST_LOCKED;
                        timer <= '0;
                    end else begin
                        if (x_valid) err <= 1'b1;
                        if (timer_last) begin
                            state <= ST_LOCKED;
                            timer <= '0;
                        end else begin
                            timer <= timer - TMW'(1);
                        end
                    end
                end
                ST_PROGRAM: begin
                    if (x_valid && bcd_ok && eq_master) begin
                        err   <= 1'b1;
                        timer <= TIMER_MAX;
                    end else if (x_valid && bcd_ok) begin
                        pin   <= x_in;
                        state <= ST_LOCKED;
                        timer <= '0;
                    end else begin
                        if (x_valid) err <= 1'b1;
                        if (timer_last) begin
                            state <= ST_LOCKED;
                            timer <= '0;
                        end else begin
                            timer <= timer - TMW'(1);
                        end
                    end
                end
                default: state <= ST_LOCKED;
            endcase
        end
    end

endmodule

// File: tb/tb_pin_lock_ctrl.sv
// Self-checking bench for pin_lock_ctrl: directed scenarios followed by
// random traffic, all compared against a behavioural model of the lock.
module tb_pin_lock_ctrl;

    localparam int MAXT   = 3;
    localparam int UCYC   = 8;
    localparam int MASTER = 'h80;
    localparam int UPIN   = 'h03;

    logic       clock;
    logic       reset;
    logic [7:0] x_in;
    logic       x_valid;
    logic       prog_en;
    logic [1:0] y_out;
    logic [1:0] tries_left;
    logic       alarm;
    logic       err;

    int total = 0;
    int bad   = 0;

    // Model: state as its y_out code, remaining idle cycles before relock.
    int m_st, m_tries, m_pin, m_left;
    bit m_err;

    pin_lock_ctrl #(
        .DIGITS        (2),
        .MAX_TRIES     (MAXT),
        .USER_PIN_INIT (8'h03),
        .MASTER_PIN    (8'h80),
        .UNLOCK_CYCLES (UCYC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .x_in       (x_in),
        .x_valid    (x_valid),
        .prog_en    (prog_en),
        .y_out      (y_out),
        .tries_left (tries_left),
        .alarm      (alarm),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit valid_bcd(int code);
        return ((code % 16) <= 9) && ((code / 16) % 16 <= 9);
    endfunction

    task automatic model_reset();
        m_st = 0; m_tries = MAXT; m_pin = UPIN; m_left = 0; m_err = 0;
    endtask

    task automatic idle_tick();
        m_left = m_left - 1;
        if (m_left <= 0) begin
            m_left = 0;
            m_st   = 0;
        end
    endtask

    task automatic model_step(bit xv, int x, bit pe);
        bit ok;
        ok    = valid_bcd(x);
        m_err = 0;
        case (m_st)
            0: if (xv) begin
                if (!ok) m_err = 1;
                else if (x == m_pin || x == MASTER) begin
                    m_st = 1; m_tries = MAXT; m_left = UCYC;
                end else begin
                    m_tries = m_tries - 1;
                    if (m_tries == 0) m_st = 2;
                end
            end
            2: if (xv) begin
                if (!ok) m_err = 1;
                else if (x == MASTER) begin m_st = 0; m_tries = MAXT; end
            end
            1: begin
                if (pe) begin
                    m_st = 3; m_left = UCYC;
                    if (xv && !ok) m_err = 1;
                end else if (xv && ok) begin
                    m_st = 0; m_left = 0;
                end else begin
                    if (xv) m_err = 1;
                    idle_tick();
                end
            end
            default: begin
                if (xv && ok && x == MASTER) begin
                    m_err = 1; m_left = UCYC;
                end else if (xv && ok) begin
                    m_pin = x; m_st = 0; m_left = 0;
                end else begin
                    if (xv) m_err = 1;
                    idle_tick();
                end
            end
        endcase
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".y"},     32'(y_out),      32'(m_st));
        check({tag, ".tries"}, 32'(tries_left), 32'(m_tries));
        check({tag, ".alarm"}, 32'(alarm),      32'(m_st == 2));
        check({tag, ".err"},   32'(err),        32'(m_err));
    endtask

    // Drive one cycle of inputs, clock it, then compare after the edge.
    task automatic cyc(string tag, bit xv, int x, bit pe);
        x_valid = xv;
        x_in    = 8'(x);
        prog_en = pe;
        @(posedge clock);
        #1;
        model_step(xv, x, pe);
        x_valid = 1'b0;
        prog_en = 1'b0;
        check_all(tag);
    endtask

    function automatic int rand_code();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 2) return m_pin;
        if (r < 4) return MASTER;
        if (r == 4) return int'($urandom_range(10, 15)) * 16 + int'($urandom_range(0, 15));
        return int'($urandom_range(0, 9)) * 16 + int'($urandom_range(0, 9));
    endfunction

    initial begin
        int cnt;
        int x;
        bit xv, pe;

        reset = 1'b1; x_in = '0; x_valid = 1'b0; prog_en = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clock);
        reset = 1'b0;

        // Wrong-entry lockout then user PIN ignored while blocked.
        cyc("wrong1", 1, 'h29, 0);
        cyc("wrong2", 1, 'h26, 0);
        cyc("wrong3", 1, 'h10, 0);
        check("blocked_alarm", 32'(alarm), 32'd1);
        cyc("blk_user", 1, 'h03, 0);
        cyc("blk_other", 1, 'h21, 0);
        cyc("blk_master", 1, 'h80, 0);
        check("recover_tries", 32'(tries_left), 32'd3);
        cyc("wrong92", 1, 'h92, 0);
        cyc("unlock03", 1, 'h03, 0);
        cyc("relock_any", 1, 'h45, 0);

        // Invalid BCD, twice back-to-back.
        cyc("bad3A", 1, 'h3A, 0);
        check("bad3A_err", 32'(err), 32'd1);
        cyc("badF1", 1, 'hF1, 0);
        cyc("idle_after_bad", 0, 0, 0);

        // Auto-relock duration.
        cyc("unlock_ar", 1, 'h03, 0);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            cyc("autorelock", 0, 0, 0);
            if (y_out == 2'b01) cnt++;
        end
        check("relock_len", 32'(cnt), 32'(UCYC));

        // Programming a new PIN.
        cyc("unlock_p", 1, 'h03, 0);
        cyc("prog_en", 0, 0, 1);
        cyc("prog_master", 1, 'h80, 0);
        cyc("prog_57", 1, 'h57, 0);
        cyc("old_pin", 1, 'h03, 0);
        cyc("new_pin", 1, 'h57, 0);
        cyc("prio", 1, 'h11, 1);

        // Asynchronous reset while programming.
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clock);
        reset = 1'b0;
        cyc("post_rst_unlock", 1, 'h03, 0);
        cyc("post_rst_relock", 1, 'h00, 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            xv = ($urandom_range(0, 1) == 1);
            pe = ($urandom_range(0, 5) == 0);
            x  = rand_code();
            if (pe && xv && !valid_bcd(x)) x = 'h42;
            cyc("rand", xv, x, pe);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
